cd_hps_mailbox: RTL and testbench

CD_HPS_MAILBOX -- requirements
Module: cd_hps_mailbox

---
 rtl/cd_hps_mailbox.sv | 131 +++++++++++++
 tb/tb_cd_hps_mailbox.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cd_hps_mailbox.sv
// HPS mailbox: toggle-flagged commands into a FWFT FIFO, status words published with a toggle and held.
// Commands reach cmd_valid one cycle after detection; drops when full (sticky flag); stat_ready only when idle.
module cd_hps_mailbox #(
  parameter int CMD_DEPTH   = 4,
  parameter int HOLD_CYCLES = 4096
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [48:0] cd_out,
  output logic [48:0] cd_in,
  output logic        cmd_valid,
  output logic [47:0] cmd_data,
  input  logic        cmd_ready,
  output logic [4:0]  cmd_level,
  output logic        cmd_overflow,
  input  logic        stat_valid,
  input  logic [47:0] stat_data,
  output logic        stat_ready
);

  localparam int         AW        = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam logic [4:0] FULL_LVL  = 5'(CMD_DEPTH);
  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PUBLISH,
    ST_HOLD
  } stat_state_t;

  logic          armed;
  logic          tog_prev;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_next;
  logic [47:0]   mem [CMD_DEPTH];
  logic          detect;
  logic          full;
  logic          pop;
  logic          push;
  logic [4:0]    level_next;

  stat_state_t   stat_state;
  logic [15:0]   hold_cnt;

  assign detect    = armed && (cd_out[48] != tog_prev);
  assign full      = (cmd_level == FULL_LVL);
  assign pop       = cmd_valid && cmd_ready;
  // A full FIFO still takes the command when the head leaves in the same cycle.
  assign push      = detect && (!full || pop);
  assign rd_next   = pop ? AW'(rd_ptr + 1'b1) : rd_ptr;
  assign cmd_valid = (cmd_level != 5'd0);

  always_comb begin
    level_next = cmd_level;
    if (push && !pop)
      level_next = cmd_level + 5'd1;
    else if (pop && !push)
      level_next = cmd_level - 5'd1;
  end

  always_ff @(posedge clk_sys) begin
    if (push)
      mem[wr_ptr] <= cd_out[47:0];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      armed        <= 1'b0;
      tog_prev     <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cmd_level    <= 5'd0;
      cmd_overflow <= 1'b0;
      cmd_data     <= 48'd0;
    end else begin
      if (!armed) begin
        armed    <= 1'b1;
        tog_prev <= cd_out[48];
      end else if (detect) begin
        tog_prev <= cd_out[48];
        if (!push)
          cmd_overflow <= 1'b1;
      end
      if (push)
        wr_ptr <= AW'(wr_ptr + 1'b1);
      rd_ptr    <= rd_next;
      cmd_level <= level_next;
      // The registered head bypasses memory when the incoming word becomes the head.
      if (level_next != 5'd0)
        cmd_data <= (push && (wr_ptr == rd_next)) ? cd_out[47:0] : mem[rd_next];
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      stat_state <= ST_IDLE;
      stat_ready <= 1'b1;
      hold_cnt   <= 16'd0;
      cd_in      <= 49'd0;
    end else begin
      case (stat_state)
        ST_IDLE: begin
          if (stat_valid) begin
            cd_in[47:0] <= stat_data;
            stat_ready  <= 1'b0;
            stat_state  <= ST_PUBLISH;
          end
        end
        ST_PUBLISH: begin
          cd_in[48]  <= ~cd_in[48];
          hold_cnt   <= HOLD_LOAD;
          stat_state <= ST_HOLD;
        end
        ST_HOLD: begin
          if (hold_cnt == 16'd0) begin
            stat_ready <= 1'b1;
            stat_state <= ST_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 16'd1;
          end
        end
        default: begin
          stat_ready <= 1'b1;
          stat_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cd_hps_mailbox.sv
// Randomised and directed bench for cd_hps_mailbox against a queue/timeline reference model.
module tb_cd_hps_mailbox;

  localparam int DEPTH = 4;
  localparam int HOLD  = 8;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b0;
  logic [48:0] cd_out = 49'd0;
  logic [48:0] cd_in;
  logic        cmd_valid;
  logic [47:0] cmd_data;
  logic        cmd_ready = 1'b0;
  logic [4:0]  cmd_level;
  logic        cmd_overflow;
  logic        stat_valid = 1'b0;
  logic [47:0] stat_data = 48'd0;
  logic        stat_ready;

  cd_hps_mailbox #(.CMD_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .cd_out       (cd_out),
    .cd_in        (cd_in),
    .cmd_valid    (cmd_valid),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .cmd_level    (cmd_level),
    .cmd_overflow (cmd_overflow),
    .stat_valid   (stat_valid),
    .stat_data    (stat_data),
    .stat_ready   (stat_ready)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  // Reference model: command FIFO as a queue, status as a timeline of accept edges.
  logic [47:0] q[$];
  bit          m_armed;
  bit          m_prev;
  bit          m_ovf;
  logic [47:0] m_head;
  logic [47:0] m_pay;
  bit          m_tog;
  bit          m_rdy;
  int          m_edge = 0;
  int          m_last_acc;
  int          m_flip_at;

  function automatic void model_reset();
    q.delete();
    m_armed    = 0;
    m_prev     = 0;
    m_ovf      = 0;
    m_head     = 48'd0;
    m_pay      = 48'd0;
    m_tog      = 0;
    m_rdy      = 1;
    m_last_acc = -1000;
    m_flip_at  = -1;
  endfunction

  function automatic void model_step();
    bit do_pop;
    bit new_cmd;
    m_edge++;
    do_pop  = (q.size() != 0) && cmd_ready;
    new_cmd = m_armed && (cd_out[48] != m_prev);
    if (!m_armed) begin
      m_armed = 1;
      m_prev  = cd_out[48];
    end
    if (do_pop)
      void'(q.pop_front());
    if (new_cmd) begin
      m_prev = cd_out[48];
      if (q.size() < DEPTH)
        q.push_back(cd_out[47:0]);
      else
        m_ovf = 1;
    end
    if (q.size() != 0)
      m_head = q[0];
    if (m_rdy && stat_valid) begin
      m_pay      = stat_data;
      m_flip_at  = m_edge + 1;
      m_last_acc = m_edge;
    end else if (m_edge == m_flip_at) begin
      m_tog = !m_tog;
    end
    m_rdy = (m_edge >= m_last_acc + HOLD + 1);
  endfunction

  task automatic check_all();
    check("cmd_valid", cmd_valid, q.size() != 0);
    check("cmd_level", cmd_level, q.size());
    check("cmd_data", cmd_data, m_head);
    check("cmd_overflow", cmd_overflow, m_ovf);
    check("cd_in", cd_in, {m_tog, m_pay});
    check("stat_ready", stat_ready, m_rdy);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_sys);
    #1;
    check_all();
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #2;
    model_reset();
    check("rst_cd_in", cd_in, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_cmd_level", cmd_level, 0);
    check("rst_cmd_overflow", cmd_overflow, 0);
    check("rst_cmd_data", cmd_data, 0);
    @(posedge clk_sys);
    #1;
    reset = 1'b0;
    check("rst_stat_ready", stat_ready, 1);
  endtask

  task automatic toggle_cmd(input logic [47:0] pl);
    cd_out = {~cd_out[48], pl};
  endtask

  initial begin
    logic [63:0] r;
    int          low;
    bit          was_rdy;

    cd_out = {1'b1, 48'd0};
    #1;
    apply_reset();

    // Arming with toggle already high must not write.
    repeat (3) cycle();
    check("arm_no_write", cmd_level, 0);

    cd_out = {1'b0, 48'h0000_1234_5678};
    cycle();
    check("first_valid", cmd_valid, 1);
    check("first_data", cmd_data, 48'h0000_1234_5678);
    cmd_ready = 1'b1;
    cycle();
    cmd_ready = 1'b0;
    check("first_pop_level", cmd_level, 0);

    for (int i = 0; i < 5; i++) begin
      toggle_cmd(48'h00A0_0000_0000 + 48'(i));
      cycle();
    end
    cycle();
    check("ovf_level", cmd_level, DEPTH);
    check("ovf_flag", cmd_overflow, 1);
    check("ovf_head", cmd_data, 48'h00A0_0000_0000);
    cmd_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      check("drain_order", cmd_data, 48'h00A0_0000_0000 + 48'(k));
      cycle();
    end
    cmd_ready = 1'b0;
    check("drain_empty", cmd_valid, 0);

    apply_reset();
    cycle();
    for (int i = 0; i < DEPTH; i++) begin
      toggle_cmd(48'h00B0_0000_0000 + 48'(i));
      cycle();
    end
    check("full_level", cmd_level, DEPTH);
    toggle_cmd(48'h00B0_0000_00FF);
    cmd_ready = 1'b1;
    cycle();
    cmd_ready = 1'b0;
    check("full_pop_push_level", cmd_level, DEPTH);
    check("full_pop_push_ovf", cmd_overflow, 0);
    cmd_ready = 1'b1;
    repeat (DEPTH) cycle();
    cmd_ready = 1'b0;

    stat_data  = 48'hABCD;
    stat_valid = 1'b1;
    cycle();
    stat_valid = 1'b0;
    check("stat_payload", cd_in[47:0], 48'hABCD);
    check("stat_tog_before", cd_in[48], 0);
    check("stat_ready_low", stat_ready, 0);
    cycle();
    check("stat_tog_after", cd_in[48], 1);
    low = 2;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (stat_ready) break;
      low++;
    end
    check("stat_low_cycles", low, HOLD + 1);

    stat_data  = 48'h1357_9BDF_0246;
    stat_valid = 1'b1;
    cycle();
    stat_valid = 1'b0;
    repeat (4) cycle();
    check("hold_cd_in_set", cd_in, {1'b0, 48'h1357_9BDF_0246});
    apply_reset();

    for (int n = 0; n < 800; n++) begin
      r = {$urandom(), $urandom()};
      if ($urandom_range(0, 2) == 0)
        toggle_cmd(r[47:0]);
      else if ($urandom_range(0, 3) == 0)
        cd_out[47:0] = r[47:0];
      cmd_ready = (n < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      if (!stat_valid && ($urandom_range(0, 3) == 0)) begin
        r          = {$urandom(), $urandom()};
        stat_valid = 1'b1;
        stat_data  = r[47:0];
      end
      was_rdy = stat_ready;
      cycle();
      if (stat_valid && was_rdy)
        stat_valid = 1'b0;
      if (n == 500)
        apply_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
